// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: queues retired stores,
// forwards exact-cover loads, stalls partial overlaps, drains when the port is idle.
module store_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [2:0]            st_size,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [2:0]            ld_size,
  output logic                  ld_stall,
  output logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  fence_req,
  output logic                  fence_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [2:0]            mem_size,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned EXT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [2:0]            ent_size [DEPTH];
  logic [DEPTH-1:0]      ent_valid;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  hit;
  logic [PTR_W-1:0]      yng;
  logic [2:0]            ld_n;
  logic                  fwd;
  logic                  ld_rd;
  logic                  drain;
  logic                  push;
  logic                  st_size_ok;
  logic [DATA_WIDTH-1:0] fwd_data;

  // Access width in bytes; zero marks an encoding that touches no bytes.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      3'b000, 3'b100: size_bytes = 3'd1;
      3'b001, 3'b101: size_bytes = 3'd2;
      3'b010:         size_bytes = 3'd4;
      default:        size_bytes = 3'd0;
    endcase
  endfunction

  assign ld_n       = size_bytes(ld_size);
  assign st_size_ok = (st_size == 3'b000) || (st_size == 3'b001) || (st_size == 3'b010);

  // Scan oldest to youngest so the last overlapping entry seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic [EXT_W-1:0] lo_a;
    logic [EXT_W-1:0] hi_a;
    logic [EXT_W-1:0] lo_e;
    logic [EXT_W-1:0] hi_e;
    hit  = 1'b0;
    yng  = '0;
    idx  = '0;
    lo_a = {1'b0, ld_addr};
    hi_a = lo_a + EXT_W'(ld_n);
    lo_e = '0;
    hi_e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx  = head + PTR_W'(i);
      lo_e = {1'b0, ent_addr[idx]};
      hi_e = lo_e + EXT_W'(size_bytes(ent_size[idx]));
      if (ent_valid[idx] && (lo_a < hi_e) && (lo_e < hi_a)) begin
        hit = 1'b1;
        yng = idx;
      end
    end
  end

  assign fwd   = hit && (ent_addr[yng] == ld_addr) && (size_bytes(ent_size[yng]) >= ld_n);
  assign ld_rd = ld_valid && !hit;
  assign drain = (count != '0) && !ld_rd;
  assign push  = st_valid && st_ready && st_size_ok;

  // Extract and extend the forwarded bytes according to the load type.
  always_comb begin
    fwd_data = '0;
    case (ld_size)
      3'b000:  fwd_data = {{(DATA_WIDTH-8){ent_data[yng][7]}}, ent_data[yng][7:0]};
      3'b100:  fwd_data = {{(DATA_WIDTH-8){1'b0}}, ent_data[yng][7:0]};
      3'b001:  fwd_data = {{(DATA_WIDTH-16){ent_data[yng][15]}}, ent_data[yng][15:0]};
      3'b101:  fwd_data = {{(DATA_WIDTH-16){1'b0}}, ent_data[yng][15:0]};
      3'b010:  fwd_data = ent_data[yng];
      default: fwd_data = '0;
    endcase
  end

  assign fence_done = (count == '0);

  // Port and load-result outputs; reset forces every output to its idle value.
  always_comb begin
    st_ready       = 1'b1;
    ld_stall       = 1'b0;
    ld_data        = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_size       = '0;
    if (!rst) begin
      st_ready = (count != CNT_W'(DEPTH)) && !(fence_req && !fence_done);
      if (ld_valid) begin
        if (ld_rd) begin
          ld_data = (ld_n != 3'd0) ? mem_read_data : '0;
        end else if (fwd) begin
          ld_data = fwd_data;
        end else begin
          ld_stall = 1'b1;
        end
      end
      if (ld_rd) begin
        mem_read = 1'b1;
        mem_addr = ld_addr;
        mem_size = ld_size;
      end else if (drain) begin
        mem_write      = 1'b1;
        mem_addr       = ent_addr[head];
        mem_write_data = ent_data[head];
        mem_size       = ent_size[head];
      end
    end
  end

  // FIFO state: push at tail, pop at head on each drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_size[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_addr[tail]  <= st_addr;
        ent_data[tail]  <= st_data;
        ent_size[tail]  <= st_size;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(drain);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_size;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_size;
  logic        ld_stall;
  logic [31:0] ld_data;
  logic        fence_req;
  logic        fence_done;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_size;
  logic [31:0] mem_read_data;

  int vectors = 0;
  int errors  = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_stall(ld_stall), .ld_data(ld_data),
    .fence_req(fence_req), .fence_done(fence_done),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdfun(input logic [31:0] a);
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  assign mem_read_data = mem_read ? rdfun(mem_addr) : 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } ent_t;

  ent_t q[$];
  logic exp_drain = 1'b0;
  logic exp_push  = 1'b0;

  function automatic int nb(input logic [2:0] s);
    case (s)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] s);
    case (s)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b101:  return {16'h0, d[15:0]};
      3'b010:  return d;
      default: return 32'h0;
    endcase
  endfunction

  // True when any byte of the load range equals any byte of the entry range.
  function automatic bit overlaps(input ent_t e, input logic [31:0] a, input int n);
    bit r = 0;
    for (int b = 0; b < n; b++)
      for (int c = 0; c < nb(e.size); c++)
        if (a + 32'(b) == e.addr + 32'(c)) r = 1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model evaluated mid-cycle and compared against every output.
  always @(negedge clk) begin
    logic        e_ready, e_fdone, e_stall, e_rd, e_wr;
    logic [31:0] e_ldata, e_maddr, e_wdata;
    logic [2:0]  e_msize;
    int          n, found;
    e_ready = 1; e_fdone = 1; e_stall = 0; e_rd = 0; e_wr = 0;
    e_ldata = 0; e_maddr = 0; e_wdata = 0; e_msize = 0;
    exp_drain = 0; exp_push = 0;
    if (!rst) begin
      e_fdone = (q.size() == 0);
      e_ready = (q.size() != DEPTH) && !(fence_req && q.size() != 0);
      if (ld_valid) begin
        n = nb(ld_size);
        found = -1;
        if (n > 0)
          for (int k = q.size() - 1; k >= 0; k--)
            if (found < 0 && overlaps(q[k], ld_addr, n)) found = k;
        if (found < 0) begin
          e_rd = 1;
          e_ldata = (n > 0) ? rdfun(ld_addr) : 32'h0;
        end else if (q[found].addr == ld_addr && nb(q[found].size) >= n) begin
          e_ldata = extend(q[found].data, ld_size);
        end else begin
          e_stall = 1;
        end
      end
      if (e_rd) begin
        e_maddr = ld_addr; e_msize = ld_size;
      end else if (q.size() > 0) begin
        e_wr = 1; e_maddr = q[0].addr; e_wdata = q[0].data; e_msize = q[0].size;
      end
      exp_drain = e_wr;
      exp_push  = st_valid && e_ready && (st_size == 3'b000 || st_size == 3'b001 || st_size == 3'b010);
    end
    chk("st_ready", 32'(st_ready), 32'(e_ready));
    chk("fence_done", 32'(fence_done), 32'(e_fdone));
    chk("ld_stall", 32'(ld_stall), 32'(e_stall));
    chk("ld_data", ld_data, e_ldata);
    chk("mem_read", 32'(mem_read), 32'(e_rd));
    chk("mem_write", 32'(mem_write), 32'(e_wr));
    chk("mem_addr", mem_addr, e_maddr);
    chk("mem_write_data", mem_write_data, e_wdata);
    chk("mem_size", 32'(mem_size), 32'(e_msize));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      if (exp_drain) void'(q.pop_front());
      if (exp_push) q.push_back('{addr: st_addr, data: st_data, size: st_size});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    st_valid = 1; st_addr = a; st_data = d; st_size = s;
    tick();
    st_valid = 0;
  endtask

  initial begin
    rst = 1; st_valid = 0; st_addr = 0; st_data = 0; st_size = 0;
    ld_valid = 0; ld_addr = 0; ld_size = 0; fence_req = 0;
    tick(); tick();
    settle();
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_fence_done", 32'(fence_done), 32'd1);
    tick();
    rst = 0;

    // Single SW drains on the following cycle.
    st_valid = 1; st_addr = 32'h100; st_data = 32'hDEADBEEF; st_size = 3'b010;
    settle();
    chk("sw_accept_ready", 32'(st_ready), 32'd1);
    tick();
    st_valid = 0;
    settle();
    chk("sw_drain_we", 32'(mem_write), 32'd1);
    chk("sw_drain_addr", mem_addr, 32'h100);
    chk("sw_drain_data", mem_write_data, 32'hDEADBEEF);
    chk("sw_drain_size", 32'(mem_size), 32'd2);
    tick();
    settle();
    chk("sw_empty", 32'(fence_done), 32'd1);
    tick();

    // Forwarding SB to LB (sign) and LBU (zero), drain in the same cycle.
    push(32'h104, 32'h80, 3'b000);
    ld_valid = 1; ld_addr = 32'h104; ld_size = 3'b000;
    settle();
    chk("lb_fwd_stall", 32'(ld_stall), 32'd0);
    chk("lb_fwd_data", ld_data, 32'hFFFFFF80);
    chk("lb_fwd_rd", 32'(mem_read), 32'd0);
    chk("lb_fwd_drain_addr", mem_addr, 32'h104);
    tick();
    ld_valid = 0;
    push(32'h104, 32'h80, 3'b000);
    ld_valid = 1; ld_size = 3'b100;
    settle();
    chk("lbu_fwd_data", ld_data, 32'h00000080);
    tick();

    // Partial overlap stalls until the store drains.
    ld_valid = 0;
    push(32'h201, 32'h12, 3'b000);
    ld_valid = 1; ld_addr = 32'h200; ld_size = 3'b010;
    settle();
    chk("lw_partial_stall", 32'(ld_stall), 32'd1);
    chk("lw_partial_we", 32'(mem_write), 32'd1);
    chk("lw_partial_waddr", mem_addr, 32'h201);
    tick();
    settle();
    chk("lw_release_stall", 32'(ld_stall), 32'd0);
    chk("lw_release_rd", 32'(mem_read), 32'd1);
    chk("lw_release_data", ld_data, 32'hC0DE0200);
    tick();

    // Fill while loads occupy the port, then drain in FIFO order.
    ld_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1; st_addr = 32'h10 + 32'(4 * i); st_data = 32'(i + 1); st_size = 3'b010;
      settle();
      chk("fill_no_drain", 32'(mem_write), 32'd0);
      tick();
    end
    st_addr = 32'h20; st_data = 32'h99;
    settle();
    chk("full_st_ready", 32'(st_ready), 32'd0);
    chk("full_fence_done", 32'(fence_done), 32'd0);
    tick();
    st_valid = 0; ld_valid = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("fifo_drain_we", 32'(mem_write), 32'd1);
      chk("fifo_drain_addr", mem_addr, 32'h10 + 32'(4 * i));
      chk("fifo_drain_data", mem_write_data, 32'(i + 1));
      tick();
    end
    settle();
    chk("fifo_empty_we", 32'(mem_write), 32'd0);
    tick();

    // Youngest matching store wins the forward.
    ld_valid = 1; ld_addr = 32'h300; ld_size = 3'b010;
    push(32'h400, 32'h1111, 3'b010);
    push(32'h400, 32'h2222, 3'b010);
    ld_addr = 32'h400;
    settle();
    chk("youngest_data", ld_data, 32'h2222);
    chk("youngest_stall", 32'(ld_stall), 32'd0);
    chk("youngest_drain_data", mem_write_data, 32'h1111);
    tick();
    ld_valid = 0;
    tick(); tick();

    // Fence blocks new stores until the buffer empties.
    ld_valid = 1; ld_addr = 32'h300;
    push(32'h500, 32'h5, 3'b010);
    fence_req = 1; st_valid = 1; st_addr = 32'h504; st_data = 32'h6; st_size = 3'b010;
    settle();
    chk("fence_ready_low", 32'(st_ready), 32'd0);
    chk("fence_not_done", 32'(fence_done), 32'd0);
    tick();
    ld_valid = 0;
    settle();
    chk("fence_drain_addr", mem_addr, 32'h500);
    tick();
    settle();
    chk("fence_done_set", 32'(fence_done), 32'd1);
    chk("fence_ready_back", 32'(st_ready), 32'd1);
    tick();
    st_valid = 0; fence_req = 0;
    settle();
    chk("fence_post_addr", mem_addr, 32'h504);
    tick();

    // An unsupported store size is accepted but buffers nothing.
    push(32'h700, 32'h7, 3'b011);
    settle();
    chk("bad_size_empty", 32'(fence_done), 32'd1);
    chk("bad_size_no_we", 32'(mem_write), 32'd0);
    tick();

    // Reset mid-drain discards the pending stores.
    ld_valid = 1; ld_addr = 32'h300;
    for (int i = 0; i < 4; i++) push(32'h600 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010);
    ld_valid = 0;
    settle();
    chk("pre_rst_drain_addr", mem_addr, 32'h600);
    tick();
    rst = 1;
    #1;
    chk("rst_async_we", 32'(mem_write), 32'd0);
    chk("rst_async_done", 32'(fence_done), 32'd1);
    chk("rst_async_addr", mem_addr, 32'h0);
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("post_rst_no_we", 32'(mem_write), 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
